// File: rtl/rob_pkg.sv
// Shared encodings and entry layout for the parametrised reorder buffer.
package rob_pkg;

  localparam int ROB_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    T_BR   = 2'd0,
    T_ST   = 2'd1,
    T_JALR = 2'd2,
    T_RG   = 2'd3
  } rob_type_e;

  typedef enum logic {
    ST_IS = 1'b0,
    ST_WR = 1'b1
  } rob_status_e;

  typedef struct packed {
    logic        busy;
    rob_status_e status;
    rob_type_e   rtype;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] jaddr;
  } rob_entry_t;

endpackage

// File: rtl/rob_search.sv
// Operand lookup for one regfile search port: commit bypass, wb0, wb1, then stored entry.
// Latency: combinational. Backpressure: none, pure lookup.
module rob_search
  import rob_pkg::*;
#(
  parameter int IDW = 4
) (
  input  logic [IDW-1:0] search_id,
  input  logic           entry_busy,
  input  logic           entry_wr,
  input  logic [31:0]    entry_val,
  input  logic           commit_ready,
  input  logic [IDW-1:0] commit_rob_id,
  input  logic [31:0]    commit_val,
  input  logic           wb0_ready,
  input  logic [IDW-1:0] wb0_rob_id,
  input  logic [31:0]    wb0_value,
  input  logic           wb1_ready,
  input  logic [IDW-1:0] wb1_rob_id,
  input  logic [31:0]    wb1_value,
  output logic           hit,
  output logic [31:0]    val
);

  always_comb begin
    hit = 1'b0;
    val = entry_val;
    // The committed value is not in the regfile until the edge after commit_ready.
    if (commit_ready && commit_rob_id == search_id) begin
      hit = 1'b1;
      val = commit_val;
    end else if (wb0_ready && wb0_rob_id == search_id) begin
      hit = 1'b1;
      val = wb0_value;
    end else if (wb1_ready && wb1_rob_id == search_id) begin
      hit = 1'b1;
      val = wb1_value;
    end else if (entry_busy && entry_wr) begin
      hit = 1'b1;
      val = entry_val;
    end
  end

endmodule

// File: rtl/rob_param.sv
// Reorder buffer: in-order commit of one entry per cycle, flush on BR mispredict; ROB_PERF_EN adds counters.
// Latency: writeback edge N -> registered commit at edge N+1; search is zero-latency.
// Backpressure: rob_full blocks allocation, head ST waits on store_done, rdy_in low freezes everything.
module rob_param
  import rob_pkg::*;
#(
  parameter  int DEPTH = ROB_DEPTH_DEF,
  localparam int IDW   = $clog2(DEPTH)
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  output logic           rob_full,
  output logic           rob_empty,
  output logic [IDW-1:0] empty_rob_id,
  input  logic           dec_ready,
  input  logic [31:0]    j_addr,
  input  logic [1:0]     op_type,   // decoder "type"; renamed since type is a reserved word
  input  logic [4:0]     rd,
  input  logic           wb0_ready,
  input  logic [IDW-1:0] wb0_rob_id,
  input  logic [31:0]    wb0_value,
  input  logic           wb1_ready,
  input  logic [IDW-1:0] wb1_rob_id,
  input  logic [31:0]    wb1_value,
  output logic           store_req,
  input  logic           store_done,
  output logic           commit_ready,
  output logic [IDW-1:0] commit_rob_id,
  output logic [4:0]     commit_reg_id,
  output logic [31:0]    commit_val,
  output logic           clear,
  output logic [31:0]    corr_jump_addr,
  output logic           melt,
  input  logic [IDW-1:0] search_rob_id_1,
  output logic           search_ready_1,
  output logic [31:0]    search_val_1,
  input  logic [IDW-1:0] search_rob_id_2,
  output logic           search_ready_2,
  output logic [31:0]    search_val_2,
  output logic [31:0]    perf_commits,
  output logic [31:0]    perf_flushes
);

  localparam logic [IDW:0]   CNT_FULL = (IDW+1)'(DEPTH);
  localparam logic [IDW:0]   CNT_ONE  = (IDW+1)'(1);
  localparam logic [IDW-1:0] PTR_ONE  = IDW'(1);

  rob_entry_t     ent [DEPTH];
  rob_entry_t     head_ent;
  logic [IDW-1:0] head, tail;
  logic [IDW:0]   count;
  logic           alloc_en, commit_en, flush_en;

  assign head_ent     = ent[head];
  assign rob_full     = (count == CNT_FULL);
  assign rob_empty    = (count == '0);
  assign empty_rob_id = tail;
  assign store_req    = head_ent.busy && (head_ent.rtype == T_ST) && !clear;

  // A pending clear owns the cycle: nothing else is accepted until the flush lands.
  assign flush_en = rdy_in && clear;
  assign alloc_en = rdy_in && !clear && dec_ready && !rob_full;

  always_comb begin
    commit_en = 1'b0;
    if (rdy_in && !clear && head_ent.busy) begin
      if (head_ent.rtype == T_ST) commit_en = store_done;
      else                        commit_en = (head_ent.status == ST_WR);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush_en) begin
      for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
    end else if (rdy_in) begin
      if (wb0_ready && ent[wb0_rob_id].busy) begin
        ent[wb0_rob_id].status <= ST_WR;
        ent[wb0_rob_id].val    <= wb0_value;
      end
      // Issued after wb0 so that wb1 wins a same-id collision.
      if (wb1_ready && ent[wb1_rob_id].busy) begin
        ent[wb1_rob_id].status <= ST_WR;
        ent[wb1_rob_id].val    <= wb1_value;
      end
      if (commit_en) ent[head].busy <= 1'b0;
      if (alloc_en) begin
        ent[tail] <= '{busy: 1'b1, status: ST_IS, rtype: rob_type_e'(op_type),
                       rd: rd, val: '0, jaddr: j_addr};
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      commit_ready   <= 1'b0;
      commit_rob_id  <= '0;
      commit_reg_id  <= '0;
      commit_val     <= '0;
      clear          <= 1'b0;
      corr_jump_addr <= '0;
      melt           <= 1'b0;
    end else if (flush_en) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_ready <= 1'b0;
      clear        <= 1'b0;
      melt         <= 1'b0;
    end else if (rdy_in) begin
      if (alloc_en)  tail <= tail + PTR_ONE;
      if (commit_en) head <= head + PTR_ONE;
      case ({alloc_en, commit_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      commit_ready <= commit_en && (head_ent.rtype == T_RG || head_ent.rtype == T_JALR);
      melt         <= commit_en && (head_ent.rtype == T_JALR);
      clear        <= commit_en && (head_ent.rtype == T_BR) && (head_ent.val != head_ent.jaddr);
      if (commit_en) begin
        commit_rob_id <= head;
        commit_reg_id <= head_ent.rd;
        commit_val    <= (head_ent.rtype == T_JALR) ? head_ent.jaddr : head_ent.val;
        if (head_ent.rtype == T_JALR ||
            (head_ent.rtype == T_BR && head_ent.val != head_ent.jaddr))
          corr_jump_addr <= head_ent.val;
      end
    end
  end

  rob_search #(.IDW(IDW)) u_search_1 (
    .search_id     (search_rob_id_1),
    .entry_busy    (ent[search_rob_id_1].busy),
    .entry_wr      (ent[search_rob_id_1].status == ST_WR),
    .entry_val     (ent[search_rob_id_1].val),
    .commit_ready  (commit_ready),
    .commit_rob_id (commit_rob_id),
    .commit_val    (commit_val),
    .wb0_ready     (wb0_ready),
    .wb0_rob_id    (wb0_rob_id),
    .wb0_value     (wb0_value),
    .wb1_ready     (wb1_ready),
    .wb1_rob_id    (wb1_rob_id),
    .wb1_value     (wb1_value),
    .hit           (search_ready_1),
    .val           (search_val_1)
  );

  rob_search #(.IDW(IDW)) u_search_2 (
    .search_id     (search_rob_id_2),
    .entry_busy    (ent[search_rob_id_2].busy),
    .entry_wr      (ent[search_rob_id_2].status == ST_WR),
    .entry_val     (ent[search_rob_id_2].val),
    .commit_ready  (commit_ready),
    .commit_rob_id (commit_rob_id),
    .commit_val    (commit_val),
    .wb0_ready     (wb0_ready),
    .wb0_rob_id    (wb0_rob_id),
    .wb0_value     (wb0_value),
    .wb1_ready     (wb1_ready),
    .wb1_rob_id    (wb1_rob_id),
    .wb1_value     (wb1_value),
    .hit           (search_ready_2),
    .val           (search_val_2)
  );

`ifdef ROB_PERF_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perf_commits <= '0;
      perf_flushes <= '0;
    end else begin
      if (commit_en) perf_commits <= perf_commits + 32'd1;
      if (flush_en)  perf_flushes <= perf_flushes + 32'd1;
    end
  end
`else
  assign perf_commits = '0;
  assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_rob_param.sv
// Scoreboarded bench for rob_param at DEPTH=4; commits are popped against expectations queued at writeback.
module tb_rob_param;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic           clk_in = 1'b0;
  logic           rst_in, rdy_in, rob_full, rob_empty;
  logic [IDW-1:0] empty_rob_id;
  logic           dec_ready;
  logic [31:0]    j_addr;
  logic [1:0]     op_type;
  logic [4:0]     rd;
  logic           wb0_ready, wb1_ready;
  logic [IDW-1:0] wb0_rob_id, wb1_rob_id;
  logic [31:0]    wb0_value, wb1_value;
  logic           store_req, store_done;
  logic           commit_ready;
  logic [IDW-1:0] commit_rob_id;
  logic [4:0]     commit_reg_id;
  logic [31:0]    commit_val;
  logic           clear, melt;
  logic [31:0]    corr_jump_addr;
  logic [IDW-1:0] search_rob_id_1, search_rob_id_2;
  logic           search_ready_1, search_ready_2;
  logic [31:0]    search_val_1, search_val_2;
  logic [31:0]    perf_commits, perf_flushes;

  rob_param #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_full(rob_full), .rob_empty(rob_empty), .empty_rob_id(empty_rob_id),
    .dec_ready(dec_ready), .j_addr(j_addr), .op_type(op_type), .rd(rd),
    .wb0_ready(wb0_ready), .wb0_rob_id(wb0_rob_id), .wb0_value(wb0_value),
    .wb1_ready(wb1_ready), .wb1_rob_id(wb1_rob_id), .wb1_value(wb1_value),
    .store_req(store_req), .store_done(store_done),
    .commit_ready(commit_ready), .commit_rob_id(commit_rob_id),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val),
    .clear(clear), .corr_jump_addr(corr_jump_addr), .melt(melt),
    .search_rob_id_1(search_rob_id_1), .search_ready_1(search_ready_1), .search_val_1(search_val_1),
    .search_rob_id_2(search_rob_id_2), .search_ready_2(search_ready_2), .search_val_2(search_val_2),
    .perf_commits(perf_commits), .perf_flushes(perf_flushes)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [IDW-1:0] id;
    logic [4:0]     rg;
    logic [31:0]    val;
  } exp_t;

  exp_t           exp_q[$];
  int             n_chk = 0;
  int             n_err = 0;
  int             n_commit = 0;
  logic [IDW-1:0] exp_tail;
  logic           rdy_q;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic push(input logic [IDW-1:0] id, input logic [4:0] rg, input logic [31:0] v);
    exp_t e;
    e.id = id; e.rg = rg; e.val = v;
    exp_q.push_back(e);
    n_commit++;
  endtask

  always @(posedge clk_in) rdy_q <= rdy_in;

  // Commit monitor: every registered commit must match the oldest queued expectation.
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (!rst_in && rdy_q && commit_ready) begin
      if (exp_q.size() == 0) chk_eq("sb_unexpected", commit_ready, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk_eq("sb_id",  commit_rob_id, e.id);
        chk_eq("sb_reg", commit_reg_id, e.rg);
        chk_eq("sb_val", commit_val,    e.val);
      end
    end
  end

  initial begin : main
    logic [IDW-1:0] id, prev_id;
    logic [4:0]     prev_rd;
    rst_in = 1'b1; rdy_in = 1'b1; dec_ready = 1'b0; j_addr = '0; op_type = 2'd3; rd = '0;
    wb0_ready = 1'b0; wb0_rob_id = '0; wb0_value = '0;
    wb1_ready = 1'b0; wb1_rob_id = '0; wb1_value = '0;
    store_done = 1'b0; search_rob_id_1 = '0; search_rob_id_2 = '0;
    exp_tail = '0; prev_id = '0; prev_rd = '0;
    tick(); tick();
    chk_eq("rst_empty", rob_empty, 1'b1);
    chk_eq("rst_full", rob_full, 1'b0);
    chk_eq("rst_tail", empty_rob_id, '0);
    chk_eq("rst_commit", commit_ready, 1'b0);
    chk_eq("rst_clear", clear, 1'b0);
    chk_eq("rst_streq", store_req, 1'b0);
    chk_eq("rst_perf", perf_commits, '0);
    rst_in = 1'b0;
    tick();

    // Fill to full, then one more allocation that must be ignored.
    for (int i = 0; i < 5; i++) begin
      dec_ready = 1'b1; op_type = 2'd3; rd = 5'(i + 1); j_addr = '0;
      tick();
      if (i < DEPTH) exp_tail = exp_tail + 1'b1;
      if (i == 2) chk_eq("full_early", rob_full, 1'b0);
    end
    dec_ready = 1'b0;
    chk_eq("full", rob_full, 1'b1);
    chk_eq("full_tail", empty_rob_id, exp_tail);
    chk_eq("full_nonempty", rob_empty, 1'b0);

    // Drain: dual-port writeback, then a same-id collision where wb1 must win.
    wb0_ready = 1'b1; wb0_rob_id = 2'd0; wb0_value = 32'hA0;
    wb1_ready = 1'b1; wb1_rob_id = 2'd1; wb1_value = 32'hB1;
    push(2'd0, 5'd1, 32'hA0); push(2'd1, 5'd2, 32'hB1);
    tick();
    wb0_rob_id = 2'd2; wb0_value = 32'hDEAD; wb1_rob_id = 2'd2; wb1_value = 32'hB2;
    push(2'd2, 5'd3, 32'hB2);
    tick();
    wb1_ready = 1'b0; wb0_rob_id = 2'd3; wb0_value = 32'hA3;
    push(2'd3, 5'd4, 32'hA3);
    tick();
    wb0_ready = 1'b0;
    repeat (3) tick();
    chk_eq("drain_empty", rob_empty, 1'b1);
    chk_eq("drain_tail", empty_rob_id, exp_tail);

    // RG writeback -> commit next edge; search sees the same-cycle wb value.
    id = exp_tail;
    dec_ready = 1'b1; op_type = 2'd3; rd = 5'd5;
    tick();
    dec_ready = 1'b0; exp_tail = exp_tail + 1'b1;
    wb0_ready = 1'b1; wb0_rob_id = id; wb0_value = 32'h1234;
    search_rob_id_1 = id; search_rob_id_2 = id + 2'd1;
    #1;
    chk_eq("srch_wb_rdy", search_ready_1, 1'b1);
    chk_eq("srch_wb_val", search_val_1, 32'h1234);
    chk_eq("srch_idle_rdy", search_ready_2, 1'b0);
    push(id, 5'd5, 32'h1234);
    tick();
    wb0_ready = 1'b0;
    #1;
    chk_eq("rg_not_yet", commit_ready, 1'b0);
    chk_eq("srch_ent_rdy", search_ready_1, 1'b1);
    chk_eq("srch_ent_val", search_val_1, 32'h1234);
    tick();
    chk_eq("rg_commit", commit_ready, 1'b1);
    chk_eq("rg_reg", commit_reg_id, 5'd5);
    chk_eq("rg_val", commit_val, 32'h1234);
    chk_eq("srch_byp_rdy", search_ready_1, 1'b1);
    chk_eq("srch_byp_val", search_val_1, 32'h1234);

    // BR mispredict: clear pulse, redirect, decoder traffic ignored during flush.
    id = exp_tail;
    dec_ready = 1'b1; op_type = 2'd0; rd = '0; j_addr = 32'h100;
    tick();
    dec_ready = 1'b0; exp_tail = exp_tail + 1'b1;
    wb0_ready = 1'b1; wb0_rob_id = id; wb0_value = 32'h104;
    tick();
    wb0_ready = 1'b0;
    tick();
    n_commit++;
    chk_eq("br_clear", clear, 1'b1);
    chk_eq("br_corr", corr_jump_addr, 32'h104);
    chk_eq("br_cr", commit_ready, 1'b0);
    dec_ready = 1'b1; op_type = 2'd3;
    tick();
    dec_ready = 1'b0; exp_tail = '0;
    chk_eq("flush_clear", clear, 1'b0);
    chk_eq("flush_empty", rob_empty, 1'b1);
    chk_eq("flush_tail", empty_rob_id, exp_tail);

    // Correctly predicted BR: no clear.
    id = exp_tail;
    dec_ready = 1'b1; op_type = 2'd0; j_addr = 32'h200;
    tick();
    dec_ready = 1'b0; exp_tail = exp_tail + 1'b1;
    wb0_ready = 1'b1; wb0_rob_id = id; wb0_value = 32'h200;
    tick();
    wb0_ready = 1'b0;
    tick();
    n_commit++;
    chk_eq("brok_clear", clear, 1'b0);
    chk_eq("brok_empty", rob_empty, 1'b1);

    // JALR: link value committed, redirect to target, melt for one cycle.
    id = exp_tail;
    dec_ready = 1'b1; op_type = 2'd2; rd = 5'd1; j_addr = 32'h44;
    tick();
    dec_ready = 1'b0; exp_tail = exp_tail + 1'b1;
    wb0_ready = 1'b1; wb0_rob_id = id; wb0_value = 32'h300;
    push(id, 5'd1, 32'h44);
    tick();
    wb0_ready = 1'b0;
    tick();
    chk_eq("jalr_cr", commit_ready, 1'b1);
    chk_eq("jalr_melt", melt, 1'b1);
    chk_eq("jalr_corr", corr_jump_addr, 32'h300);
    chk_eq("jalr_val", commit_val, 32'h44);
    tick();
    chk_eq("jalr_melt_off", melt, 1'b0);

    // ST waits for store_done regardless of status.
    dec_ready = 1'b1; op_type = 2'd1; rd = '0; j_addr = '0;
    tick();
    dec_ready = 1'b0; exp_tail = exp_tail + 1'b1;
    chk_eq("st_req", store_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("st_hold_req", store_req, 1'b1);
      chk_eq("st_hold_busy", rob_empty, 1'b0);
    end
    store_done = 1'b1;
    tick();
    store_done = 1'b0;
    n_commit++;
    chk_eq("st_req_off", store_req, 1'b0);
    chk_eq("st_cr", commit_ready, 1'b0);
    chk_eq("st_empty", rob_empty, 1'b1);
    chk_eq("st_tail", empty_rob_id, exp_tail);

    // Steady state wrap: one alloc and one commit every cycle.
    for (int i = 0; i < 12; i++) begin
      dec_ready = 1'b1; op_type = 2'd3; rd = 5'(i + 8);
      if (i > 0) begin
        wb0_ready = 1'b1; wb0_rob_id = prev_id; wb0_value = 32'h5000 + 32'(i);
        push(prev_id, prev_rd, 32'h5000 + 32'(i));
      end
      prev_id = exp_tail; prev_rd = rd;
      tick();
      exp_tail = exp_tail + 1'b1;
      chk_eq("wrap_tail", empty_rob_id, exp_tail);
      if (i >= 2) begin
        chk_eq("wrap_cr", commit_ready, 1'b1);
        chk_eq("wrap_nonempty", rob_empty, 1'b0);
      end
    end
    dec_ready = 1'b0;
    wb0_ready = 1'b1; wb0_rob_id = prev_id; wb0_value = 32'h6000;
    push(prev_id, prev_rd, 32'h6000);
    tick();
    wb0_ready = 1'b0;
    repeat (3) tick();
    chk_eq("wrap_empty", rob_empty, 1'b1);

    // Build live state, freeze with rdy_in low, then async reset.
    id = exp_tail;
    dec_ready = 1'b1; op_type = 2'd3; rd = 5'd7;
    tick();
    exp_tail = exp_tail + 1'b1;
    rd = 5'd9; wb0_ready = 1'b1; wb0_rob_id = id; wb0_value = 32'h77;
    push(id, 5'd7, 32'h77);
    tick();
    dec_ready = 1'b0; wb0_ready = 1'b0; exp_tail = exp_tail + 1'b1;
    tick();
    chk_eq("pre_frz_cr", commit_ready, 1'b1);
    rdy_in = 1'b0; dec_ready = 1'b1;
    tick(); tick();
    chk_eq("frz_cr", commit_ready, 1'b1);
    chk_eq("frz_tail", empty_rob_id, exp_tail);
    chk_eq("frz_nonempty", rob_empty, 1'b0);
    chk_eq("sb_drain", exp_q.size(), 0);
`ifdef ROB_PERF_EN
    chk_eq("perf_commits", perf_commits, n_commit);
    chk_eq("perf_flushes", perf_flushes, 32'd1);
`else
    chk_eq("perf_commits", perf_commits, '0);
    chk_eq("perf_flushes", perf_flushes, '0);
`endif
    #2;
    rst_in = 1'b1;
    #1;
    chk_eq("arst_empty", rob_empty, 1'b1);
    chk_eq("arst_tail", empty_rob_id, '0);
    chk_eq("arst_cr", commit_ready, 1'b0);
    chk_eq("arst_val", commit_val, '0);
    chk_eq("arst_reg", commit_reg_id, '0);
    chk_eq("arst_corr", corr_jump_addr, '0);
    chk_eq("arst_perf_c", perf_commits, '0);
    chk_eq("arst_perf_f", perf_flushes, '0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
